// File: rtl/video_blitter.sv
// rtl/video_blitter.sv - memory-to-video fill/copy DMA engine with iomem register window
//
// Purpose:
//   The CPU programs SRC/DST/COUNT/CTRL through the iomem responder window.
//   A start command then runs the master port to fill a word run with a constant
//   (SRC holds the value) or to copy a word run from SRC to DST.
//
// Ports:
//   clk, resetn               single clock, asynchronous active-low reset
//   iomem_valid/ready         responder handshake; ready pulses one cycle per access
//   iomem_wstrb/addr/wdata    responder request; wstrb==0 means read, addr[4:2] selects a register
//   iomem_rdata               responder read data, valid while iomem_ready is high
//   m_valid/ready             initiator handshake towards the video write port
//   m_wstrb/addr/wdata        initiator request; wstrb 4'hF write, 4'h0 read
//   m_rdata                   initiator read data, sampled on m_valid && m_ready
//   irq_done                  level interrupt, done && irq_en
//
// Register map (word offsets):
//   0 CTRL   W [0] start, [1] abort (both self-clearing); R/W [2] mode (1 = copy), [3] irq_en
//   1 STATUS R [0] busy, [1] done, [2] aborted; writing 1 clears done/aborted
//   2 SRC    3 DST    4 COUNT    5 REMAIN (read-only)    6-7 read as zero

module video_blitter #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        irq_done
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

    state_t                   state_q, state_d;
    logic                     ready_q, ready_d;
    logic [31:0]              rdata_q, rdata_d;
    logic                     mode_q, mode_d;
    logic                     irq_en_q, irq_en_d;
    logic                     done_q, done_d;
    logic                     aborted_q, aborted_d;
    logic                     abort_q, abort_d;
    logic [31:0]              src_q, src_d;
    logic [31:0]              dst_q, dst_d;
    logic [31:0]              cur_src_q, cur_src_d;
    logic [31:0]              cur_dst_q, cur_dst_d;
    logic [31:0]              data_q, data_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;
    logic [COUNT_WIDTH-1:0]   remain_q, remain_d;

    logic        busy;
    logic        wr_commit;
    logic        start_wr;
    logic        abort_wr;
    logic        abort_now;
    logic [2:0]  reg_sel;
    logic [31:0] count_m;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{iomem_addr[31:5], iomem_addr[1:0]};

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return res;
    endfunction

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        aborted_d = aborted_q;
        abort_d   = abort_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cur_src_d = cur_src_q;
        cur_dst_d = cur_dst_q;
        data_d    = data_q;
        count_d   = count_q;
        remain_d  = remain_q;
        rdata_d   = 32'd0;
        count_m   = 32'd0;

        busy    = (state_q != S_IDLE);
        reg_sel = iomem_addr[4:2];

        // Request is seen on the first valid cycle, acked the next cycle; register
        // writes take effect on the ack edge while the requester still holds them.
        ready_d   = iomem_valid && !ready_q;
        wr_commit = iomem_valid && ready_q && (iomem_wstrb != 4'h0);
        start_wr  = wr_commit && (reg_sel == 3'd0) && iomem_wstrb[0] && iomem_wdata[0];
        abort_wr  = wr_commit && (reg_sel == 3'd0) && iomem_wstrb[0] && iomem_wdata[1];
        abort_now = abort_q || abort_wr;

        if (ready_d && (iomem_wstrb == 4'h0)) begin
            case (reg_sel)
                3'd0:    rdata_d = {28'd0, irq_en_q, mode_q, 2'b00};
                3'd1:    rdata_d = {29'd0, aborted_q, done_q, busy};
                3'd2:    rdata_d = src_q;
                3'd3:    rdata_d = dst_q;
                3'd4:    rdata_d = 32'(count_q);
                3'd5:    rdata_d = 32'(remain_q);
                default: rdata_d = 32'd0;
            endcase
        end

        if (wr_commit) begin
            case (reg_sel)
                3'd0: begin
                    if (iomem_wstrb[0]) begin
                        irq_en_d = iomem_wdata[3];
                        if (!busy) mode_d = iomem_wdata[2];
                    end
                end
                3'd1: begin
                    if (iomem_wstrb[0] && iomem_wdata[1]) done_d    = 1'b0;
                    if (iomem_wstrb[0] && iomem_wdata[2]) aborted_d = 1'b0;
                end
                3'd2: if (!busy) src_d = merge_bytes(src_q, iomem_wdata, iomem_wstrb);
                3'd3: if (!busy) dst_d = merge_bytes(dst_q, iomem_wdata, iomem_wstrb);
                3'd4: begin
                    if (!busy) begin
                        count_m = merge_bytes(32'(count_q), iomem_wdata, iomem_wstrb);
                        count_d = count_m[COUNT_WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end

        // Status set events below override a same-cycle W1C clear.
        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                // Abort in the same write as start cancels the start.
                if (start_wr && !abort_wr) begin
                    if (count_q == '0) begin
                        done_d = 1'b1;
                    end else begin
                        remain_d  = count_q;
                        cur_src_d = src_q;
                        cur_dst_d = dst_q;
                        // mode_d so a combined mode+start write takes the new mode
                        state_d   = mode_d ? S_RD : S_WR;
                    end
                end
            end
            S_RD: begin
                if (abort_wr) abort_d = 1'b1;
                if (m_ready) begin
                    data_d = m_rdata;
                    if (abort_now) begin
                        state_d   = S_IDLE;
                        aborted_d = 1'b1;
                        abort_d   = 1'b0;
                    end else begin
                        state_d = S_WR;
                    end
                end
            end
            S_WR: begin
                if (abort_wr) abort_d = 1'b1;
                if (m_ready) begin
                    cur_src_d = cur_src_q + 32'd4;
                    cur_dst_d = cur_dst_q + 32'd4;
                    remain_d  = remain_q - 1'b1;
                    if (abort_now) begin
                        state_d   = S_IDLE;
                        aborted_d = 1'b1;
                        abort_d   = 1'b0;
                    end else if (remain_q == COUNT_WIDTH'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = mode_q ? S_RD : S_WR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b0;
            rdata_q   <= 32'd0;
            mode_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            abort_q   <= 1'b0;
            src_q     <= 32'd0;
            dst_q     <= 32'd0;
            cur_src_q <= 32'd0;
            cur_dst_q <= 32'd0;
            data_q    <= 32'd0;
            count_q   <= '0;
            remain_q  <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            mode_q    <= mode_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            abort_q   <= abort_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            cur_src_q <= cur_src_d;
            cur_dst_q <= cur_dst_d;
            data_q    <= data_d;
            count_q   <= count_d;
            remain_q  <= remain_d;
        end
    end

    // All master outputs come straight from flops frozen while waiting on m_ready.
    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign m_valid     = (state_q != S_IDLE);
    assign m_wstrb     = (state_q == S_WR) ? 4'hF : 4'h0;
    assign m_addr      = (state_q == S_RD) ? cur_src_q : cur_dst_q;
    assign m_wdata     = mode_q ? data_q : src_q;
    assign irq_done    = done_q && irq_en_q;

endmodule

// File: tb/tb_video_blitter.sv
// tb/tb_video_blitter.sv - self-checking bench for video_blitter

module tb_video_blitter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        irq_done;

    video_blitter #(.COUNT_WIDTH(16)) dut (
        .clk(clk), .resetn(resetn),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_wstrb(m_wstrb), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .irq_done(irq_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        obs_q[$];
    txn_t        exp_q[$];
    logic [31:0] mem [logic [31:0]];
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_xfer(input logic [2:0] idx, input logic [31:0] wd,
                            input logic [3:0] strb, output logic [31:0] rd);
        int g;
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0200_0000 | {27'd0, idx, 2'b00};
        iomem_wdata = wd;
        iomem_wstrb = strb;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (iomem_ready !== 1'b1 && g < 8);
        if (iomem_ready !== 1'b1) check("iomem_ready timeout", 32'(iomem_ready), 32'd1);
        rd = iomem_rdata;
        @(negedge clk);
        check("iomem_ready one-cycle pulse", 32'(iomem_ready), 32'd0);
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
    endtask

    task automatic reg_wr(input logic [2:0] idx, input logic [31:0] wd,
                          input logic [3:0] strb = 4'hF);
        logic [31:0] dummy;
        bus_xfer(idx, wd, strb, dummy);
    endtask

    task automatic reg_rd(input logic [2:0] idx, output logic [31:0] rd);
        bus_xfer(idx, 32'd0, 4'h0, rd);
    endtask

    // Reference model: the word-level transfer list a run must produce.
    task automatic model_run(input bit copy, input logic [31:0] src, input logic [31:0] dst,
                             input int n);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            if (copy) begin
                a = src + 32'(4 * i);
                if (!mem.exists(a)) mem[a] = $urandom;
                exp_q.push_back('{4'h0, a, mem[a]});
                exp_q.push_back('{4'hF, dst + 32'(4 * i), mem[a]});
            end else begin
                exp_q.push_back('{4'hF, dst + 32'(4 * i), src});
            end
        end
    endtask

    // Answers n_hs master requests, holding m_ready low wmin..wmax cycles first.
    task automatic serve(input int n_hs, input int wmin, input int wmax);
        txn_t snap;
        int   g;
        int   wc;
        bit   stable;
        for (int h = 0; h < n_hs; h++) begin
            g = 0;
            while (m_valid !== 1'b1 && g < 40) begin
                @(negedge clk);
                g++;
            end
            if (m_valid !== 1'b1) begin
                check("m_valid timeout", 32'(m_valid), 32'd1);
                return;
            end
            snap   = '{m_wstrb, m_addr, m_wdata};
            stable = 1'b1;
            wc     = $urandom_range(wmax, wmin);
            for (int w = 0; w < wc; w++) begin
                @(negedge clk);
                if (m_valid !== 1'b1 || m_wstrb !== snap.strb || m_addr !== snap.addr ||
                    m_wdata !== snap.data) stable = 1'b0;
            end
            check("master request held stable", 32'(stable), 32'd1);
            if (snap.strb == 4'h0) begin
                m_rdata   = mem.exists(snap.addr) ? mem[snap.addr] : 32'hDEAD_BEEF;
                snap.data = m_rdata;
            end
            obs_q.push_back(snap);
            m_ready = 1'b1;
            @(negedge clk);
            m_ready = 1'b0;
        end
    endtask

    task automatic compare_run(input string tag);
        check({tag, " txn count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s[%0d] wstrb", tag, i), 32'(obs_q[i].strb), 32'(exp_q[i].strb));
            check($sformatf("%s[%0d] addr", tag, i), obs_q[i].addr, exp_q[i].addr);
            check($sformatf("%s[%0d] data", tag, i), obs_q[i].data, exp_q[i].data);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (m_valid !== 1'b0) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] src;
        logic [31:0] dst;
        bit          copy;
        bit          irq;
        int          n;

        resetn = 1'b0; iomem_valid = 1'b0; iomem_wstrb = 4'h0;
        iomem_addr = 32'd0; iomem_wdata = 32'd0; m_ready = 1'b0; m_rdata = 32'd0;
        repeat (2) @(negedge clk);
        check("reset m_valid", 32'(m_valid), 32'd0);
        check("reset iomem_ready", 32'(iomem_ready), 32'd0);
        check("reset irq_done", 32'(irq_done), 32'd0);
        check("reset iomem_rdata", iomem_rdata, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Register access, byte strobes, unused offsets
        reg_wr(3'd2, 32'hFFFF_FFFF);
        reg_wr(3'd2, 32'h1234_5678, 4'b0101);
        reg_rd(3'd2, rd); check("SRC byte strobes", rd, 32'hFF34_FF78);
        reg_wr(3'd0, 32'h0000_000C);
        reg_rd(3'd0, rd); check("CTRL readback", rd, 32'h0000_000C);
        reg_wr(3'd6, 32'hFFFF_FFFF);
        reg_rd(3'd6, rd); check("offset 6 reads zero", rd, 32'd0);
        reg_rd(3'd5, rd); check("REMAIN idle", rd, 32'd0);

        // Fill of 3 words, m_ready always granted
        reg_wr(3'd0, 32'h8);
        reg_wr(3'd2, 32'd5);
        reg_wr(3'd3, 32'h0520_0000);
        reg_wr(3'd4, 32'd3);
        model_run(1'b0, 32'd5, 32'h0520_0000, 3);
        reg_wr(3'd0, 32'h9);
        check("first m_valid after start ack", 32'(m_valid), 32'd1);
        serve(3, 0, 0);
        compare_run("fill3");
        expect_quiet("fill3 no extra requests", 3);
        reg_rd(3'd1, rd); check("fill3 STATUS", rd, 32'h2);
        check("fill3 irq_done with irq_en", 32'(irq_done), 32'd1);
        reg_rd(3'd5, rd); check("fill3 REMAIN", rd, 32'd0);
        reg_wr(3'd0, 32'h0);
        check("irq_done masked by irq_en", 32'(irq_done), 32'd0);
        reg_wr(3'd1, 32'h2);
        reg_rd(3'd1, rd); check("done W1C", rd, 32'd0);

        // Copy of 2 words, m_ready delayed 3 cycles
        mem[32'h1000] = 32'hA;
        mem[32'h1004] = 32'hB;
        reg_wr(3'd2, 32'h1000);
        reg_wr(3'd3, 32'h0520_0100);
        reg_wr(3'd4, 32'd2);
        model_run(1'b1, 32'h1000, 32'h0520_0100, 2);
        reg_wr(3'd0, 32'h5);
        serve(4, 3, 3);
        compare_run("copy2");
        reg_rd(3'd1, rd); check("copy2 STATUS", rd, 32'h2);
        reg_wr(3'd1, 32'h2);

        // COUNT = 0
        reg_wr(3'd4, 32'd0);
        reg_wr(3'd0, 32'h9);
        check("count0 done next cycle", 32'(irq_done), 32'd1);
        expect_quiet("count0 no requests", 8);
        reg_rd(3'd1, rd); check("count0 STATUS", rd, 32'h2);
        reg_wr(3'd1, 32'h2);
        reg_rd(3'd1, rd); check("count0 W1C", rd, 32'h0);

        // start and abort in one write: nothing starts
        reg_wr(3'd4, 32'd4);
        reg_wr(3'd0, 32'h3);
        expect_quiet("start+abort no requests", 6);
        reg_rd(3'd1, rd); check("start+abort not busy", rd & 32'h3, 32'h0);
        reg_rd(3'd5, rd); check("start+abort REMAIN untouched", rd, 32'd0);

        // Abort during second write of an 8-word fill
        reg_wr(3'd1, 32'h6);
        reg_wr(3'd2, 32'hCAFE_0001);
        reg_wr(3'd3, 32'h0530_0000);
        reg_wr(3'd4, 32'd8);
        model_run(1'b0, 32'hCAFE_0001, 32'h0530_0000, 2);
        reg_wr(3'd0, 32'h1);
        serve(1, 0, 0);
        reg_wr(3'd3, 32'h0999_0000);
        reg_wr(3'd0, 32'h2);
        serve(1, 0, 0);
        compare_run("abort");
        expect_quiet("abort stops requests", 6);
        reg_rd(3'd1, rd); check("abort STATUS", rd, 32'h4);
        reg_rd(3'd5, rd); check("abort REMAIN", rd, 32'd6);
        reg_rd(3'd3, rd); check("DST write while busy dropped", rd, 32'h0530_0000);
        reg_wr(3'd1, 32'h4);

        // Randomized runs
        for (int r = 0; r < 6; r++) begin
            copy = 1'($urandom_range(1, 0));
            irq  = 1'($urandom_range(1, 0));
            n    = $urandom_range(6, 1);
            src  = $urandom;
            if (copy) src = src & ~32'h3;
            dst  = (r == 0) ? 32'hFFFF_FFF8 : ($urandom & ~32'h3);
            reg_wr(3'd2, src);
            reg_wr(3'd3, dst);
            reg_wr(3'd4, 32'(n));
            model_run(copy, src, dst, n);
            reg_wr(3'd0, {28'd0, irq, copy, 1'b0, 1'b1});
            check($sformatf("rand%0d first m_valid", r), 32'(m_valid), 32'd1);
            serve(copy ? 2 * n : n, 0, 2);
            compare_run($sformatf("rand%0d", r));
            expect_quiet($sformatf("rand%0d quiet", r), 3);
            reg_rd(3'd1, rd); check($sformatf("rand%0d STATUS", r), rd, 32'h2);
            reg_rd(3'd5, rd); check($sformatf("rand%0d REMAIN", r), rd, 32'd0);
            check($sformatf("rand%0d irq_done", r), 32'(irq_done), 32'(irq));
            reg_wr(3'd1, 32'h2);
        end

        // Reset in the middle of a read
        reg_wr(3'd2, 32'h2000);
        reg_wr(3'd3, 32'h0540_0000);
        reg_wr(3'd4, 32'd4);
        reg_wr(3'd0, 32'hD);
        check("pre-reset in RD", 32'(m_valid && m_wstrb == 4'h0), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("async reset m_valid", 32'(m_valid), 32'd0);
        check("async reset iomem_ready", 32'(iomem_ready), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            reg_rd(3'(i), rd);
            check($sformatf("post-reset reg %0d", i), rd, 32'd0);
        end
        reg_wr(3'd2, 32'd7);
        reg_wr(3'd3, 32'h100);
        reg_wr(3'd4, 32'd2);
        model_run(1'b0, 32'd7, 32'h100, 2);
        reg_wr(3'd0, 32'h1);
        serve(2, 0, 1);
        compare_run("post-reset fill");
        reg_rd(3'd1, rd); check("post-reset STATUS", rd, 32'h2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
